// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the run/stop clock divider controller.
// Optional feature macro used by the top: CLKDIV_PERIOD_CNT_EN.
package clk_div_pkg;

    // Default divisor width and reset divisor (half-period = DIV+1 clocks).
    localparam int CLKDIV_W           = 16;
    localparam int CLKDIV_DEFAULT_DIV = 4999;

    // Controller states: idle, counting, counting with a divisor queued,
    // and finishing the current high phase before idling.
    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        PEND  = 2'd2,
        DRAIN = 2'd3
    } clk_div_state_e;

endpackage

// File: rtl/clk_div_counter.sv
// Half-period counter and registered divided clock.
// While run_i is low the counter sits at zero and the output clock is held low,
// so stopping never produces a short high pulse.
module clk_div_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         run_i,
    input  logic [W-1:0] div_i,
    output logic         terminal_o,
    output logic         out_clk_o,
    output logic         rise_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         out_clk_q;
    logic         out_clk_d;
    logic         rise_q;
    logic         rise_d;
    logic         terminal;

    // Next-state: count 0..div, toggle the clock at the terminal count.
    always_comb begin
        terminal  = run_i && (cnt_q == div_i);
        cnt_d     = '0;
        out_clk_d = 1'b0;
        rise_d    = 1'b0;
        if (run_i) begin
            cnt_d     = terminal ? '0 : cnt_q + 1'b1;
            out_clk_d = terminal ? ~out_clk_q : out_clk_q;
            rise_d    = terminal && !out_clk_q;
        end
    end

    // Counter, clock and rise-pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            out_clk_q <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            out_clk_q <= out_clk_d;
            rise_q    <= rise_d;
        end
    end

    assign terminal_o = terminal;
    assign out_clk_o  = out_clk_q;
    assign rise_o     = rise_q;

endmodule

// File: rtl/clk_div_sched.sv
// Run/stop and reconfiguration controller around clk_div_counter.
// New divisors are queued and only take effect at a period end (falling edge
// of out_clk_o) or when the divider is stopped, so no period is ever shortened.
// Optional macro CLKDIV_PERIOD_CNT_EN adds a 32-bit free-running count of
// output periods on period_cnt_o.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int W           = CLKDIV_W,
    parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         cfg_valid_i,
    input  logic [W-1:0] cfg_div_i,
    output logic         cfg_ready_o,
    output logic         out_clk_o,
    output logic         out_tick_o,
    output logic [W-1:0] cur_div_o,
    output logic         busy_o
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    output logic [31:0]  period_cnt_o
`endif
);

    clk_div_state_e state_q;
    clk_div_state_e state_d;
    logic [W-1:0]   cur_div_q;
    logic [W-1:0]   cur_div_d;
    logic [W-1:0]   pend_div_q;
    logic [W-1:0]   pend_div_d;
    logic           pend_vld_q;
    logic           pend_vld_d;

    logic           cfg_ready;
    logic           xfer;
    logic           run;
    logic           terminal;
    logic           out_clk;
    logic           rise;

    // Divisors are only accepted while idle or plainly running.
    assign cfg_ready = (state_q == STOP) || (state_q == RUN);
    assign xfer      = cfg_valid_i && cfg_ready;

    // The counter runs while active; in DRAIN it only runs to finish a high
    // phase, a low phase is simply abandoned.
    assign run = (state_q == RUN) || (state_q == PEND) ||
                 ((state_q == DRAIN) && out_clk);

    clk_div_counter #(
        .W (W)
    ) u_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .run_i      (run),
        .div_i      (cur_div_q),
        .terminal_o (terminal),
        .out_clk_o  (out_clk),
        .rise_o     (rise)
    );

    // FSM next-state, divisor queueing and divisor commit.
    always_comb begin
        state_d    = state_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        case (state_q)
            STOP: begin
                if (xfer) begin
                    cur_div_d = cfg_div_i;
                end
                if (en_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    pend_div_d = cfg_div_i;
                    pend_vld_d = 1'b1;
                    state_d    = en_i ? PEND : DRAIN;
                end else if (!en_i) begin
                    state_d = DRAIN;
                end
            end
            PEND: begin
                if (!en_i) begin
                    state_d = DRAIN;
                end else if (terminal && out_clk) begin
                    // Falling edge closes the period: new divisor starts here.
                    cur_div_d  = pend_div_q;
                    pend_vld_d = 1'b0;
                    state_d    = RUN;
                end
            end
            DRAIN: begin
                if (!out_clk || terminal) begin
                    state_d = STOP;
                    if (pend_vld_q) begin
                        cur_div_d  = pend_div_q;
                        pend_vld_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = STOP;
            end
        endcase
    end

    // Controller state registers; reset discards any queued divisor.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= STOP;
            cur_div_q  <= W'(DEFAULT_DIV);
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign cfg_ready_o = cfg_ready;
    assign out_clk_o   = out_clk;
    assign out_tick_o  = rise;
    assign cur_div_o   = cur_div_q;
    assign busy_o      = pend_vld_q;

`ifdef CLKDIV_PERIOD_CNT_EN
    logic [31:0] period_cnt_q;

    // Count completed rising edges; wraps naturally, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_cnt_q <= '0;
        end else if (rise) begin
            period_cnt_q <= period_cnt_q + 32'd1;
        end
    end

    assign period_cnt_o = period_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: directed scenarios plus randomized
// run/stop/reconfigure traffic, all compared every cycle against a
// phase-level reference model kept here.
module tb_clk_div_sched;

    localparam int W       = 16;
    localparam int DEF_DIV = 4999;

    logic         clk;
    logic         rst_r;
    logic         en_r;
    logic         valid_r;
    logic [W-1:0] div_r;
    logic         cfg_ready;
    logic         out_clk;
    logic         out_tick;
    logic [W-1:0] cur_div;
    logic         busy;
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [31:0]  period_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int ticks_seen = 0;

    // Reference model: phase-level view of the divider.
    bit          m_running;   // counting (with or without a queued divisor)
    bit          m_stopping;  // finishing a high phase before going idle
    bit          m_clk;
    bit          m_tick;
    int          m_rem;       // cycles left in the current phase, this one included
    int          m_cur;
    int          m_pend;
    bit          m_pend_vld;
    logic [31:0] m_pcnt;

    clk_div_sched #(
        .W           (W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_r),
        .en_i        (en_r),
        .cfg_valid_i (valid_r),
        .cfg_div_i   (div_r),
        .cfg_ready_o (cfg_ready),
        .out_clk_o   (out_clk),
        .out_tick_o  (out_tick),
        .cur_div_o   (cur_div),
        .busy_o      (busy)
`ifdef CLKDIV_PERIOD_CNT_EN
        ,
        .period_cnt_o(period_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_update();
        bit ready_pre;
        bit xfer;
        bit phase_end;
        bit reload;
        bit tick_n;
        ready_pre = !m_stopping && !m_pend_vld;
        xfer      = valid_r && ready_pre;
        tick_n    = 1'b0;
        if (rst_r) begin
            m_running  = 1'b0;
            m_stopping = 1'b0;
            m_clk      = 1'b0;
            m_tick     = 1'b0;
            m_cur      = DEF_DIV;
            m_pend_vld = 1'b0;
            m_pcnt     = '0;
        end else begin
            if (xfer) $display("cfg transfer: div=%0d en=%0d t=%0t", div_r, en_r, $time);
            m_pcnt = m_pcnt + {31'd0, m_tick};
            if (!m_running && !m_stopping) begin
                if (xfer) m_cur = div_r;
                if (en_r) begin
                    m_running = 1'b1;
                    m_rem     = m_cur + 1;
                end
            end else if (m_running) begin
                phase_end = (m_rem == 1);
                reload    = phase_end && m_clk && m_pend_vld && en_r;
                if (phase_end) begin
                    tick_n = !m_clk;
                    m_clk  = !m_clk;
                    if (reload) begin
                        m_cur      = m_pend;
                        m_pend_vld = 1'b0;
                    end
                    m_rem = m_cur + 1;
                end else begin
                    m_rem--;
                end
                if (xfer) begin
                    m_pend     = div_r;
                    m_pend_vld = 1'b1;
                end
                if (!en_r) begin
                    m_running  = 1'b0;
                    m_stopping = 1'b1;
                end
            end else begin
                if (!m_clk || m_rem == 1) begin
                    m_clk      = 1'b0;
                    m_stopping = 1'b0;
                    if (m_pend_vld) begin
                        m_cur      = m_pend;
                        m_pend_vld = 1'b0;
                    end
                end else begin
                    m_rem--;
                end
            end
            m_tick = tick_n;
        end
    endtask

    // One clock: edge, model update, then compare all outputs 1 ns later.
    task automatic step();
        logic [19:0] exp_v;
        logic [19:0] obs_v;
        @(posedge clk);
        model_update();
        #1;
        if (out_tick === 1'b1) ticks_seen++;
        exp_v = {m_clk, m_tick, m_pend_vld, (!m_stopping && !m_pend_vld), m_cur[15:0]};
        obs_v = {out_clk, out_tick, busy, cfg_ready, cur_div};
        check_eq("outs{clk,tick,busy,ready,div}", 64'(obs_v), 64'(exp_v));
`ifdef CLKDIV_PERIOD_CNT_EN
        check_eq("period_cnt", 64'(period_cnt), 64'(m_pcnt));
`endif
    endtask

    // Step until out_clk reaches lvl; n = number of steps taken.
    task automatic wait_out(input logic lvl, input int max, output int n);
        n = 0;
        while (out_clk !== lvl && n < max) begin
            step();
            n++;
        end
        if (out_clk !== lvl) check_eq("wait_timeout", 64'(out_clk), 64'(lvl));
    endtask

    task automatic go_stop();
        int n;
        en_r = 1'b0;
        n = 0;
        while ((m_running || m_stopping) && n < 20000) begin
            step();
            n++;
        end
        step();
        check_eq("stop_ready", 64'(cfg_ready), 64'd1);
    endtask

    task automatic offer(input int d);
        valid_r = 1'b1;
        div_r   = W'(d);
        step();
        valid_r = 1'b0;
    endtask

    initial begin
        int n, n_low, base;
        rst_r = 1'b1; en_r = 1'b0; valid_r = 1'b0; div_r = '0;
        m_pcnt = '0; m_rem = 1; m_pend = 0;

        // 1: reset, then run at the default divisor.
        repeat (10) step();
        check_eq("rst_out_clk", 64'(out_clk), 64'd0);
        check_eq("rst_cur_div", 64'(cur_div), 64'(DEF_DIV));
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_ready", 64'(cfg_ready), 64'd1);
        rst_r = 1'b0;
        step();
        en_r = 1'b1;
        step();
        wait_out(1'b1, 6000, n);
        check_eq("t1_first_rise", 64'(n), 64'd5000);
        base = ticks_seen;
        wait_out(1'b0, 6000, n_low);
        wait_out(1'b1, 6000, n);
        check_eq("t1_period", 64'(n_low + n), 64'd10000);
        check_eq("t1_ticks_per_period", 64'(ticks_seen - base), 64'd1);

        // 2: divisor offered during the high phase applies at period end.
        offer(1);
        check_eq("t2_busy", 64'(busy), 64'd1);
        check_eq("t2_ready", 64'(cfg_ready), 64'd0);
        wait_out(1'b0, 6000, n_low);
        check_eq("t2_old_period", 64'(n + 1 + n_low), 64'd10000);
        check_eq("t2_busy_clear", 64'(busy), 64'd0);
        check_eq("t2_new_div", 64'(cur_div), 64'd1);
        wait_out(1'b1, 10, n);
        wait_out(1'b0, 10, n_low);
        wait_out(1'b1, 10, n);
        check_eq("t2_new_period", 64'(n_low + n), 64'd4);

        // 3: divisor 0 gives CLK/2.
        go_stop();
        offer(0);
        check_eq("t3_div0", 64'(cur_div), 64'd0);
        en_r = 1'b1;
        step();
        base = ticks_seen;
        wait_out(1'b1, 10, n);
        check_eq("t3_first_rise", 64'(n), 64'd1);
        repeat (19) step();
        check_eq("t3_ticks_20cyc", 64'(ticks_seen - base), 64'd10);

        // 4: stop requested in the high phase, then in the low phase.
        go_stop();
        offer(9);
        en_r = 1'b1;
        step();
        wait_out(1'b1, 40, n);
        step();
        step();
        en_r = 1'b0;
        wait_out(1'b0, 40, n);
        check_eq("t4_high_len", 64'(n + 2), 64'd10);
        check_eq("t4_stopped_ready", 64'(cfg_ready), 64'd1);
        en_r = 1'b1;
        step();
        wait_out(1'b1, 40, n);
        wait_out(1'b0, 40, n);
        step();
        step();
        en_r = 1'b0;
        step();
        check_eq("t4_drain_ready", 64'(cfg_ready), 64'd0);
        check_eq("t4_drain_clk", 64'(out_clk), 64'd0);
        step();
        check_eq("t4_stop_ready", 64'(cfg_ready), 64'd1);

        // 5: reset while a divisor is pending.
        en_r = 1'b1;
        step();
        offer(3);
        check_eq("t5_busy", 64'(busy), 64'd1);
        repeat (5) step();
        rst_r = 1'b1;
        step();
        rst_r = 1'b0;
        en_r = 1'b0;
        check_eq("t5_rst_clk", 64'(out_clk), 64'd0);
        check_eq("t5_rst_div", 64'(cur_div), 64'(DEF_DIV));
        check_eq("t5_rst_busy", 64'(busy), 64'd0);
        check_eq("t5_rst_ready", 64'(cfg_ready), 64'd1);
        repeat (3) step();
        check_eq("t5_pend_lost", 64'(cur_div), 64'(DEF_DIV));

        // 6: EN fall and a transfer in the same RUN cycle.
        offer(2);
        en_r = 1'b1;
        repeat (7) step();
        en_r = 1'b0;
        offer(7);
        check_eq("t6_busy", 64'(busy), 64'd1);
        check_eq("t6_ready", 64'(cfg_ready), 64'd0);
        n = 0;
        while (cfg_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check_eq("t6_cur_div", 64'(cur_div), 64'd7);
        check_eq("t6_busy_clear", 64'(busy), 64'd0);

        // Randomized run/stop/reconfigure traffic against the model.
        offer(3);
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 15) == 0) en_r = ~en_r;
            valid_r = ($urandom_range(0, 7) == 0);
            div_r   = W'($urandom_range(0, 6));
            rst_r   = ($urandom_range(0, 4999) == 0);
            step();
        end
        rst_r = 1'b0;
        valid_r = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
